// File: rtl/order_book_msg_builder.sv
// Packs one order request into a 320-bit frame stamped with timestamp, sequence and checksum; first beat one cycle after capture.
// Streams BEATS beats MSB-first; tx_ready low holds the current beat stable, and requests are not accepted while a frame is in flight.
module order_book_msg_builder #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        req_type,
   input  logic [31:0]       order_id,
   input  logic [31:0]       stock_id,
   input  logic [31:0]       quantity,
   input  logic [63:0]       price,
   input  logic [7:0]        side,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_sof,
   output logic              tx_eof,
   output logic              busy
);
   localparam int BEATS = 320 / DATA_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [319:0]     frame;
   logic [CNT_W-1:0] beat_cnt;
   logic [31:0]      seq_cnt;
   logic [63:0]      ts_cnt;

   logic [303:0]     body;
   logic [15:0]      csum;
   logic [319:0]     cap_frame;
   logic [319:0]     shifted;

   // Everything above the checksum field; reserved bits are folded in as zeros.
   always_comb begin
      body = {req_type, ts_cnt, order_id, seq_cnt, stock_id, side, quantity, price, 32'd0};
      csum = '0;
      for (int i = 0; i < 19; i++) begin
         csum = csum ^ body[16*i +: 16];
      end
   end

   assign cap_frame = {body, csum};
   assign shifted   = frame << DATA_W;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         frame    <= '0;
         beat_cnt <= '0;
         seq_cnt  <= '0;
         ts_cnt   <= '0;
         in_ready <= 1'b1;
         tx_valid <= 1'b0;
         tx_sof   <= 1'b0;
         tx_eof   <= 1'b0;
         busy     <= 1'b0;
         tx_data  <= '0;
      end else begin
         ts_cnt <= ts_cnt + 64'd1;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  frame    <= cap_frame;
                  tx_data  <= cap_frame[319 -: DATA_W];
                  beat_cnt <= '0;
                  seq_cnt  <= seq_cnt + 32'd1;
                  in_ready <= 1'b0;
                  tx_valid <= 1'b1;
                  busy     <= 1'b1;
                  tx_sof   <= 1'b1;
                  tx_eof   <= (BEATS == 1);
                  state    <= SEND;
               end
            end
            SEND: begin
               // Outputs are only touched on an accepted beat, so a stall holds them.
               if (tx_ready) begin
                  frame   <= shifted;
                  tx_data <= shifted[319 -: DATA_W];
                  tx_sof  <= 1'b0;
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= IDLE;
                     beat_cnt <= '0;
                     in_ready <= 1'b1;
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     tx_eof   <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                     tx_eof   <= ((beat_cnt + 1'b1) == LAST_BEAT);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
